// File: rtl/sram_axi_mux.sv
// sram_axi_mux: round-robin N-port SRAM-like to AXI3 bridge. Each port has at most one
// single-beat transaction outstanding; responses are routed back by AXI ID.
module sram_axi_mux #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ID_W    = 4
) (
    input  logic                   i_aclk,
    input  logic                   i_aresetn,

    input  logic [N_PORTS-1:0]     i_req,
    input  logic [N_PORTS-1:0]     i_wr,
    input  logic [2*N_PORTS-1:0]   i_size,
    input  logic [4*N_PORTS-1:0]   i_wstrb,
    input  logic [32*N_PORTS-1:0]  i_addr,
    input  logic [32*N_PORTS-1:0]  i_wdata,
    output logic [N_PORTS-1:0]     o_addr_ok,
    output logic [N_PORTS-1:0]     o_data_ok,
    output logic [32*N_PORTS-1:0]  o_rdata,
    output logic [N_PORTS-1:0]     o_resp_err,

    output logic [ID_W-1:0]        o_arid,
    output logic [31:0]            o_araddr,
    output logic [7:0]             o_arlen,
    output logic [2:0]             o_arsize,
    output logic [1:0]             o_arburst,
    output logic [1:0]             o_arlock,
    output logic [3:0]             o_arcache,
    output logic [2:0]             o_arprot,
    output logic                   o_arvalid,
    input  logic                   i_arready,

    input  logic [ID_W-1:0]        i_rid,
    input  logic [31:0]            i_rdata_axi,
    input  logic [1:0]             i_rresp,
    input  logic                   i_rlast,
    input  logic                   i_rvalid,
    output logic                   o_rready,

    output logic [ID_W-1:0]        o_awid,
    output logic [31:0]            o_awaddr,
    output logic [7:0]             o_awlen,
    output logic [2:0]             o_awsize,
    output logic [1:0]             o_awburst,
    output logic [1:0]             o_awlock,
    output logic [3:0]             o_awcache,
    output logic [2:0]             o_awprot,
    output logic                   o_awvalid,
    input  logic                   i_awready,

    output logic [ID_W-1:0]        o_wid,
    output logic [31:0]            o_wdata_axi,
    output logic [3:0]             o_wstrb_axi,
    output logic                   o_wlast,
    output logic                   o_wvalid,
    input  logic                   i_wready,

    input  logic [ID_W-1:0]        i_bid,
    input  logic [1:0]             i_bresp,
    input  logic                   i_bvalid,
    output logic                   o_bready
);

    localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0]            r_busy;
    logic [N_PORTS-1:0]            r_port_wr;
    logic [PW-1:0]                 r_rr_ptr;
    logic [N_PORTS-1:0]            r_data_ok;
    logic [N_PORTS-1:0]            r_resp_err;
    logic [N_PORTS-1:0][31:0]      r_rdata;

    logic                          r_iss_vld;
    logic [ID_W-1:0]               r_iss_port;
    logic [31:0]                   r_iss_addr;
    logic [1:0]                    r_iss_size;
    logic [3:0]                    r_iss_wstrb;
    logic [31:0]                   r_iss_wdata;
    logic                          r_arvalid;
    logic                          r_awvalid;
    logic                          r_wvalid;

    logic                          w_gnt_vld;
    logic [PW-1:0]                 w_gnt_idx;
    logic [PW-1:0]                 w_cand;
    logic [PW:0]                   w_sum;
    logic [N_PORTS-1:0]            w_gnt_oh;
    logic [PW-1:0]                 w_ptr_next;

    logic                          w_sel_wr;
    logic [1:0]                    w_sel_size;
    logic [3:0]                    w_sel_wstrb;
    logic [31:0]                   w_sel_addr;
    logic [31:0]                   w_sel_wdata;

    logic [N_PORTS-1:0]            w_r_hit;
    logic [N_PORTS-1:0]            w_b_hit;
    logic                          w_ar_pend;
    logic                          w_aw_pend;
    logic                          w_w_pend;

    // First eligible port at or after the pointer, wrapping modulo N_PORTS.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        if (i_aresetn && !r_iss_vld) begin
            for (int k = 0; k < int'(N_PORTS); k++) begin
                w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(N_PORTS)) begin
                    w_sum = w_sum - (PW+1)'(N_PORTS);
                end
                w_cand = w_sum[PW-1:0];
                if (!w_gnt_vld && i_req[w_cand] && !r_busy[w_cand]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        if (w_gnt_vld) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
        end
    end

    assign w_ptr_next = (w_gnt_idx == PW'(N_PORTS - 1)) ? '0 : w_gnt_idx + PW'(1);

    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_size  = '0;
        w_sel_wstrb = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (w_gnt_oh[i]) begin
                w_sel_wr    = i_wr[i];
                w_sel_size  = i_size[2*i +: 2];
                w_sel_wstrb = i_wstrb[4*i +: 4];
                w_sel_addr  = i_addr[32*i +: 32];
                w_sel_wdata = i_wdata[32*i +: 32];
            end
        end
    end

    // A response counts only for a busy port whose outstanding transaction is of that type.
    always_comb begin
        w_r_hit = '0;
        w_b_hit = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (i_rvalid && i_rlast && (i_rid == ID_W'(i)) && r_busy[i] && !r_port_wr[i]) begin
                w_r_hit[i] = 1'b1;
            end
            if (i_bvalid && (i_bid == ID_W'(i)) && r_busy[i] && r_port_wr[i]) begin
                w_b_hit[i] = 1'b1;
            end
        end
    end

    assign w_ar_pend = r_arvalid && !i_arready;
    assign w_aw_pend = r_awvalid && !i_awready;
    assign w_w_pend  = r_wvalid  && !i_wready;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_busy      <= '0;
            r_port_wr   <= '0;
            r_rr_ptr    <= '0;
            r_data_ok   <= '0;
            r_resp_err  <= '0;
            r_rdata     <= '0;
            r_iss_vld   <= 1'b0;
            r_iss_port  <= '0;
            r_iss_addr  <= '0;
            r_iss_size  <= '0;
            r_iss_wstrb <= '0;
            r_iss_wdata <= '0;
            r_arvalid   <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
        end else begin
            r_data_ok <= w_r_hit | w_b_hit;
            r_busy    <= (r_busy & ~(w_r_hit | w_b_hit)) | w_gnt_oh;
            for (int i = 0; i < int'(N_PORTS); i++) begin
                if (w_r_hit[i]) begin
                    r_rdata[i]    <= i_rdata_axi;
                    r_resp_err[i] <= (i_rresp != 2'b00);
                end else if (w_b_hit[i]) begin
                    r_resp_err[i] <= (i_bresp != 2'b00);
                end else begin
                    r_resp_err[i] <= 1'b0;
                end
            end

            if (w_gnt_vld) begin
                r_port_wr[w_gnt_idx] <= w_sel_wr;
                r_rr_ptr    <= w_ptr_next;
                r_iss_vld   <= 1'b1;
                r_iss_port  <= ID_W'(w_gnt_idx);
                r_iss_addr  <= w_sel_addr;
                r_iss_size  <= w_sel_size;
                r_iss_wstrb <= w_sel_wstrb;
                r_iss_wdata <= w_sel_wdata;
                r_arvalid   <= !w_sel_wr;
                r_awvalid   <= w_sel_wr;
                r_wvalid    <= w_sel_wr;
            end else if (r_iss_vld) begin
                r_arvalid <= w_ar_pend;
                r_awvalid <= w_aw_pend;
                r_wvalid  <= w_w_pend;
                r_iss_vld <= w_ar_pend | w_aw_pend | w_w_pend;
            end
        end
    end

    assign o_addr_ok   = w_gnt_oh;
    assign o_data_ok   = r_data_ok;
    assign o_rdata     = r_rdata;
    assign o_resp_err  = r_resp_err;

    assign o_arid      = r_iss_port;
    assign o_araddr    = r_iss_addr;
    assign o_arlen     = 8'd0;
    assign o_arsize    = {1'b0, r_iss_size};
    assign o_arburst   = 2'b01;
    assign o_arlock    = 2'b00;
    assign o_arcache   = 4'b0000;
    assign o_arprot    = 3'b000;
    assign o_arvalid   = r_arvalid;
    assign o_rready    = i_aresetn;

    assign o_awid      = r_iss_port;
    assign o_awaddr    = r_iss_addr;
    assign o_awlen     = 8'd0;
    assign o_awsize    = {1'b0, r_iss_size};
    assign o_awburst   = 2'b01;
    assign o_awlock    = 2'b00;
    assign o_awcache   = 4'b0000;
    assign o_awprot    = 3'b000;
    assign o_awvalid   = r_awvalid;

    assign o_wid       = r_iss_port;
    assign o_wdata_axi = r_iss_wdata;
    assign o_wstrb_axi = r_iss_wstrb;
    assign o_wlast     = 1'b1;
    assign o_wvalid    = r_wvalid;
    assign o_bready    = i_aresetn;

endmodule

// File: doc/sram_axi_mux.md
Name: sram_axi_mux

Overview:
- N-port successor to the single inst/data SRAM-like-to-AXI path.
- Accepts uncached single-beat requests from N_PORTS SRAM-like masters, arbitrates round-robin, and issues each as one AXI3 transaction.
- Each port's responses are routed back by AXI ID; per-port error reporting is new.
- Sits between cpu_sram-class masters (or extra peripheral masters) and the AXI crossbar.

Parameters:
- N_PORTS, 2, number of SRAM-like ports (1..16); port index is the AXI ID.
- ID_W, 4, AXI ID width; requires 2**ID_W >= N_PORTS.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req  in  N_PORTS  per-port request
- wr  in  N_PORTS  1 = write
- size  in  2*N_PORTS  per-port size: 0 byte, 1 half, 2 word
- wstrb  in  4*N_PORTS  per-port byte strobes
- addr  in  32*N_PORTS  per-port address
- wdata  in  32*N_PORTS  per-port write data
- addr_ok  out  N_PORTS  request accepted
- data_ok  out  N_PORTS  transaction complete
- rdata  out  32*N_PORTS  per-port read data, valid with data_ok
- resp_err  out  N_PORTS  high with data_ok when rresp/bresp != 0
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  ID_W/32/8/3/2/2/4/3/1  AXI3 read address
- arready  in  1
- rid/rdata_axi/rresp/rlast/rvalid  in  ID_W/32/2/1/1  read data (rdata_axi is the AXI rdata)
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  same widths as AR
- awready  in  1
- wid/wdata_axi/wstrb_axi/wlast/wvalid  out  ID_W/32/4/1/1
- wready  in  1
- bid/bresp/bvalid  in  ID_W/2/1
- bready  out  1

Behaviour:
- Reset (async, aresetn low): addr_ok, data_ok, resp_err, arvalid, awvalid, wvalid = 0. rdata = 0. busy[] cleared. Round-robin pointer = 0. Issue register empty. In-flight transactions are dropped; the bench never resets mid-burst on a live slave.
- rready = 1 and bready = 1 whenever out of reset. Acceptance is safe because each port has at most one outstanding transaction.
- Eligible(i) = req[i] & !busy[i].
- Grant:
  - Occurs only when the issue register is empty.
  - Picks the first eligible port at or after rr_ptr, wrapping modulo N_PORTS.
  - addr_ok[i] is asserted combinationally for that one cycle.
  - The issue register latches {port, wr, addr, size, wstrb, wdata}; busy[i] is set and rr_ptr becomes i+1 (wrapping).
- Issue, read:
  - arvalid = 1 from the cycle after the grant until arready.
  - arid = port; araddr = addr; arlen = 0; arsize = {0,size}; arburst = 01; arlock, arcache, arprot = 0.
- Issue, write:
  - awvalid and wvalid rise together the cycle after the grant; each drops independently on its own handshake.
  - wlast = 1; wid = awid = port.
- Issue register empties in the cycle the last required handshake completes (AR; or both AW and W). A new grant is possible the next cycle, so peak rate is one issue per 2 cycles.
- Response:
  - Read completes on rvalid & rlast; write completes on bvalid.
  - Next cycle: data_ok[id] = 1 for exactly one cycle; rdata[id] = registered rdata_axi (reads only; unchanged on writes); resp_err[id] = (resp != 0).
  - busy[id] clears on the completion cycle, so that port may be granted in the same cycle its data_ok is high.
- Simultaneous R and B completions for different ports: both data_ok bits assert in the same cycle.
- Unknown-ID or non-busy-ID responses are ignored; busy[] is unchanged.
- Ordering:
  - Within a port: strictly in order, since only one transaction is outstanding.
  - Across ports: no ordering is guaranteed.
- Masters hold req/addr/data stable until addr_ok; the block samples only on addr_ok.

Test Plan:
- Single read, port 0: addr=0x1FC0_0000, size=2 → addr_ok 1 cycle; arvalid next cycle, arid=0, arsize=2, arlen=0; slave returns 0xDEADBEEF, rresp=0 → data_ok[0] one cycle later, rdata[0]=0xDEADBEEF, resp_err[0]=0.
- Write with AW ready at cycle 1 and W ready at cycle 4, port 1: wstrb=0b0011, wdata=0x1234 → awvalid drops after cycle 1, wvalid holds until cycle 4, wlast=1, wid=1; bvalid → data_ok[1]=1 next cycle.
- All 4 ports (N_PORTS=4) request reads continuously, rr_ptr=0 → grant order 0,1,2,3,0…; no port is starved; grants arrive no faster than every 2 cycles.
- Out-of-order responses: port 0 read and port 1 write outstanding; B for id 1 arrives before R for id 0 → data_ok[1] precedes data_ok[0], each with correct data.
- Error and blocking: rresp=2 → resp_err=1 with data_ok; a second req from a busy port gets no addr_ok until the cycle of its completion.
- aresetn asserted low mid-transaction → all valid/ok outputs drop to 0 immediately; after release, busy is clear and a fresh read completes normally.
